// File: rtl/waveform_pkg.sv
// Shared types for the waveform sweep controller.
//   sweep_mode_e  : sweep behaviour once the stop endpoint is reached
//   sweep_state_e : controller FSM states
//   decode_mode() : maps the raw 2-bit mode field, reserved code -> SINGLE
package waveform_pkg;

  typedef enum logic [1:0] {
    SINGLE   = 2'd0,
    REPEAT   = 2'd1,
    PINGPONG = 2'd2
  } sweep_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    STEP  = 2'd2,
    DONE  = 2'd3
  } sweep_state_e;

  function automatic sweep_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return REPEAT;
      2'd2:    return PINGPONG;
      default: return SINGLE;
    endcase
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter that times how long each sweep point is held.
// Ports:
//   clk, rst_in  : clock, synchronous active-high reset
//   load_i       : load load_val_i (wins over counting)
//   en_i         : count down while nonzero
//   load_val_i   : cycles-minus-one to hold the point
//   expired_o    : count has reached zero
module dwell_timer #(
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_in,
  input  logic                   load_i,
  input  logic                   en_i,
  input  logic [DWELL_WIDTH-1:0] load_val_i,
  output logic                   expired_o
);

  logic [DWELL_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - DWELL_WIDTH'(1);
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/waveform_sweep_ctrl.sv
// Frequency-sweep scheduler driving the waveform generator's freq_in/enable.
// Walks from a start word to a stop word in clamped steps, holding each
// point for max(cfg_dwell,1) cycles plus one STEP cycle.
// Ports:
//   clk, rst_in      : clock, synchronous active-high reset
//   start, abort     : launch (IDLE only) / terminate (any state)
//   cfg_start_freq   : first frequency word
//   cfg_stop_freq    : last frequency word (direction from start/stop order)
//   cfg_step         : unsigned step magnitude
//   cfg_dwell        : cycles per point, 0 treated as 1
//   cfg_mode         : 0 single, 1 repeat, 2 ping-pong, 3 as single
//   freq_out         : frequency word to the generator
//   enable_out       : generator enable
//   busy             : sweep in progress
//   done             : one-cycle pulse on normal completion
module waveform_sweep_ctrl
  import waveform_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_in,
  input  logic                   start,
  input  logic                   abort,
  input  logic [WIDTH-1:0]       cfg_start_freq,
  input  logic [WIDTH-1:0]       cfg_stop_freq,
  input  logic [WIDTH-1:0]       cfg_step,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic [1:0]             cfg_mode,
  output logic [WIDTH-1:0]       freq_out,
  output logic                   enable_out,
  output logic                   busy,
  output logic                   done
);

  sweep_state_e           state_q;
  logic [WIDTH-1:0]       freq_q;
  logic                   enable_q, busy_q, done_q;

  // Latched sweep configuration; start/stop/direction swap in ping-pong.
  logic [WIDTH-1:0]       start_q, stop_q, step_q;
  logic [DWELL_WIDTH-1:0] dwell_q;
  sweep_mode_e            mode_q;
  logic                   up_q, one_pt_q;

  logic                   accept, at_end, expired, timer_load;
  logic [DWELL_WIDTH-1:0] timer_val;
  logic [WIDTH-1:0]       next_pt_d;

  // One step from cur toward lim in WIDTH+1 bits; carry/borrow or
  // overshooting lim clamps the result to lim.
  function automatic logic [WIDTH-1:0] clamp_step(input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] stp,
                                                  input logic [WIDTH-1:0] lim,
                                                  input logic             up);
    logic [WIDTH:0] ext;
    if (up) begin
      ext = {1'b0, cur} + {1'b0, stp};
      if (ext[WIDTH] || (ext[WIDTH-1:0] > lim)) return lim;
    end else begin
      ext = {1'b0, cur} - {1'b0, stp};
      if (ext[WIDTH] || (ext[WIDTH-1:0] < lim)) return lim;
    end
    return ext[WIDTH-1:0];
  endfunction

  function automatic logic [DWELL_WIDTH-1:0] dwell_reload(input logic [DWELL_WIDTH-1:0] d);
    return (d == '0) ? '0 : d - DWELL_WIDTH'(1);
  endfunction

  assign accept = (state_q == IDLE) && start && !abort;
  assign at_end = (freq_q == stop_q);

  // Timer is loaded as each DWELL is entered: from the raw config on start,
  // from the latched copy on every STEP.
  assign timer_load = accept || (state_q == STEP);
  assign timer_val  = accept ? dwell_reload(cfg_dwell) : dwell_reload(dwell_q);

  dwell_timer #(.DWELL_WIDTH(DWELL_WIDTH)) u_dwell_timer (
    .clk        (clk),
    .rst_in     (rst_in),
    .load_i     (timer_load),
    .en_i       (state_q == DWELL),
    .load_val_i (timer_val),
    .expired_o  (expired)
  );

  always_comb begin
    next_pt_d = clamp_step(freq_q, step_q, stop_q, up_q);
    if (one_pt_q) begin
      next_pt_d = freq_q;
    end else if (at_end) begin
      case (mode_q)
        REPEAT:   next_pt_d = start_q;
        // Step away from the endpoint toward the old start, so the
        // endpoint is not dwelt twice.
        PINGPONG: next_pt_d = clamp_step(freq_q, step_q, start_q, !up_q);
        default:  next_pt_d = freq_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      start_q  <= cfg_start_freq;
      stop_q   <= cfg_stop_freq;
      step_q   <= cfg_step;
      dwell_q  <= cfg_dwell;
      mode_q   <= decode_mode(cfg_mode);
      up_q     <= (cfg_stop_freq >= cfg_start_freq);
      one_pt_q <= (cfg_step == '0) || (cfg_start_freq == cfg_stop_freq);
    end else if ((state_q == STEP) && at_end && (mode_q == PINGPONG) && !one_pt_q) begin
      start_q <= stop_q;
      stop_q  <= start_q;
      up_q    <= !up_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q  <= IDLE;
      freq_q   <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if ((state_q != IDLE) && abort) begin
        state_q  <= IDLE;
        enable_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              state_q  <= DWELL;
              freq_q   <= cfg_start_freq;
              enable_q <= 1'b1;
              busy_q   <= 1'b1;
            end
          end
          DWELL: begin
            if (expired) begin
              if ((mode_q == SINGLE) && (at_end || one_pt_q)) begin
                state_q  <= DONE;
                enable_q <= 1'b0;
                done_q   <= 1'b1;
              end else begin
                state_q <= STEP;
              end
            end
          end
          STEP: begin
            freq_q  <= next_pt_d;
            state_q <= DWELL;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign freq_out   = freq_q;
  assign enable_out = enable_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_waveform_sweep_ctrl.sv
// Bench for waveform_sweep_ctrl: table of sweep vectors with hand-computed
// point sequences, plus hand-written abort/reset/handshake sequences.
module tb_waveform_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] cfg_start_freq = '0;
  logic [15:0] cfg_stop_freq = '0;
  logic [15:0] cfg_step = '0;
  logic [15:0] cfg_dwell = '0;
  logic [1:0]  cfg_mode = '0;
  logic [15:0] freq_out;
  logic        enable_out, busy, done;

  int n_pass = 0;
  int n_total = 0;

  waveform_sweep_ctrl #(.WIDTH(16), .DWELL_WIDTH(16)) dut (
    .clk            (clk),
    .rst_in         (rst_in),
    .start          (start),
    .abort          (abort),
    .cfg_start_freq (cfg_start_freq),
    .cfg_stop_freq  (cfg_stop_freq),
    .cfg_step       (cfg_step),
    .cfg_dwell      (cfg_dwell),
    .cfg_mode       (cfg_mode),
    .freq_out       (freq_out),
    .enable_out     (enable_out),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]  st;
    logic [15:0]  sp;
    logic [15:0]  stp;
    logic [15:0]  dw;
    logic [1:0]   mode;
    int           n;       // number of points listed
    logic [127:0] pts;     // point k in bits [16k +: 16]
    bit           single;  // ends with done; otherwise ended by abort
  } vec_t;

  vec_t tab [8];

  function automatic logic [127:0] pk(input logic [15:0] a0, a1, a2, a3,
                                      input logic [15:0] a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic chk_out(input string nm, input logic [15:0] f, input logic en,
                         input logic bz, input logic dn);
    chk({nm, ".freq"},   32'(freq_out),   32'(f));
    chk({nm, ".enable"}, 32'(enable_out), 32'(en));
    chk({nm, ".busy"},   32'(busy),       32'(bz));
    chk({nm, ".done"},   32'(done),       32'(dn));
  endtask

  task automatic chk_idle(input string nm, input logic [15:0] f);
    chk_out(nm, f, 1'b0, 1'b0, 1'b0);
  endtask

  // Inputs change on the falling edge; outputs are sampled on the falling edge.
  task automatic launch(input vec_t v);
    cfg_start_freq = v.st;
    cfg_stop_freq  = v.sp;
    cfg_step       = v.stp;
    cfg_dwell      = v.dw;
    cfg_mode       = v.mode;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // disturb: pulse start and scramble cfg_* during point 1 of the sweep.
  task automatic run_vec(input int idx, input vec_t v, input bit disturb);
    int d, h;
    logic [15:0] e;
    string nm;
    d = (v.dw == 0) ? 1 : int'(v.dw);
    e = '0;
    launch(v);
    for (int k = 0; k < v.n; k++) begin
      e = v.pts[k*16 +: 16];
      if (k == v.n - 1) h = v.single ? d : 1;
      else              h = d + 1;
      for (int j = 0; j < h; j++) begin
        nm = $sformatf("v%0d.p%0d.c%0d", idx, k, j);
        chk_out(nm, e, 1'b1, 1'b1, 1'b0);
        if (disturb && k == 1 && j == 1) begin
          start = 1'b1;
          cfg_start_freq = 16'd7;
          cfg_stop_freq  = 16'd9000;
          cfg_step       = 16'd1;
          cfg_mode       = 2'd1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (v.single) begin
      chk_out($sformatf("v%0d.done", idx), e, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      chk_idle($sformatf("v%0d.idle", idx), e);
    end else begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk_idle($sformatf("v%0d.abort", idx), e);
    end
    @(negedge clk);
  endtask

  initial begin
    tab[0] = '{16'd100, 16'd130, 16'd10, 16'd3, 2'd0, 4,
               pk(16'd100, 16'd110, 16'd120, 16'd130, 0, 0, 0, 0), 1'b1};
    tab[1] = '{16'd50, 16'd5, 16'd20, 16'd1, 2'd0, 4,
               pk(16'd50, 16'd30, 16'd10, 16'd5, 0, 0, 0, 0), 1'b1};
    tab[2] = '{16'd10, 16'd0, 16'd30, 16'd1, 2'd0, 2,
               pk(16'd10, 16'd0, 0, 0, 0, 0, 0, 0), 1'b1};
    tab[3] = '{16'd0, 16'd2, 16'd1, 16'd1, 2'd2, 7,
               pk(16'd0, 16'd1, 16'd2, 16'd1, 16'd0, 16'd1, 16'd2, 0), 1'b0};
    tab[4] = '{16'hFFF0, 16'hFFFF, 16'h0020, 16'd0, 2'd1, 4,
               pk(16'hFFF0, 16'hFFFF, 16'hFFF0, 16'hFFFF, 0, 0, 0, 0), 1'b0};
    tab[5] = '{16'd7, 16'd9, 16'd1, 16'd2, 2'd3, 3,
               pk(16'd7, 16'd8, 16'd9, 0, 0, 0, 0, 0), 1'b1};
    tab[6] = '{16'd40, 16'd90, 16'd0, 16'd2, 2'd0, 1,
               pk(16'd40, 0, 0, 0, 0, 0, 0, 0), 1'b1};
    tab[7] = '{16'd5, 16'd5, 16'd3, 16'd1, 2'd1, 3,
               pk(16'd5, 16'd5, 16'd5, 0, 0, 0, 0, 0), 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    rst_in = 1'b0;
    chk_idle("reset", 16'd0);
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(i, tab[i], 1'b0);

    // start pulsed (with changed cfg) while busy must not alter the sweep
    run_vec(8, tab[0], 1'b1);

    // Abort mid-dwell at 120, then restart the next cycle at 100
    launch(tab[0]);
    repeat (8) @(negedge clk);
    chk_out("abt.pre", 16'd120, 1'b1, 1'b1, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_idle("abt.post", 16'd120);
    launch(tab[0]);
    chk_out("abt.restart", 16'd100, 1'b1, 1'b1, 1'b0);

    // Reset mid-sweep
    repeat (5) @(negedge clk);
    chk_out("rst.pre", 16'd110, 1'b1, 1'b1, 1'b0);
    rst_in = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
    chk_idle("rst.mid", 16'd0);

    // start + abort together in IDLE: no sweep
    start = 1'b1;
    abort = 1'b1;
    cfg_start_freq = 16'd33;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk_idle("sa.idle0", 16'd0);
    @(negedge clk);
    chk_idle("sa.idle1", 16'd0);

    // Reset wins over a simultaneous start + abort, and over a plain start
    start = 1'b1;
    rst_in = 1'b1;
    @(negedge clk);
    chk_idle("rst.start", 16'd0);
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    rst_in = 1'b0;
    chk_idle("rst.sa", 16'd0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/waveform_sweep_ctrl.md
# waveform_sweep_ctrl

Frequency-sweep scheduler for the waveform generator. It walks the generator's frequency word from a start value to a stop value in fixed steps, holds each value for a programmable dwell, and drives the generator's `freq_in`/`enable` inputs. Modes are single, repeat and ping-pong. A start/busy/done handshake lets a host or test sequencer launch a sweep and detect its end.

## Interface
- `WIDTH`, 16: frequency word width; matches the generator's `freq_in`.
- `DWELL_WIDTH`, 16: dwell counter width.
- `clk`  in  1: single clock; the only clock domain.
- `rst_in`  in  1: reset, synchronous, active-high.
- `start`  in  1: launch sweep; sampled only in IDLE.
- `abort`  in  1: terminate sweep; sampled in every state.
- `cfg_start_freq`  in  WIDTH: first frequency word.
- `cfg_stop_freq`  in  WIDTH: last frequency word. Direction is up if stop ≥ start, else down.
- `cfg_step`  in  WIDTH: unsigned step magnitude.
- `cfg_dwell`  in  DWELL_WIDTH: cycles each point is held; 0 is treated as 1.
- `cfg_mode`  in  2: 0 single, 1 repeat, 2 ping-pong, 3 reserved (behaves as single).
- `freq_out`  out  WIDTH: to generator `freq_in`.
- `enable_out`  out  1: to generator `enable`.
- `busy`  out  1: high from the cycle after the accepted start until return to IDLE.
- `done`  out  1: one-cycle pulse on normal completion.

## Operation
- FSM states:
  - IDLE: on `start` && !`abort`, latch all `cfg_*` and go to DWELL.
  - DWELL: count the dwell. At dwell end, go to STEP, or to DONE if the current point is the final endpoint in single mode.
  - STEP: compute the next point and return to DWELL.
  - DONE: pulse `done`, go to IDLE.
- Config is latched at start. Changes to `cfg_*` mid-sweep have no effect.
- Step arithmetic is done in WIDTH+1 bits:
  - Up: next = cur + step. If the carry is set or next > stop, next = stop.
  - Down: next = cur − step. If a borrow occurs or next < stop, next = stop.
- Endpoint reached (cur == stop at dwell end):
  - single: go to DONE.
  - repeat: next = start.
  - ping-pong: swap the latched start/stop, invert direction, and step away from the endpoint. The endpoint is not dwelt twice.
- `cfg_step` == 0 or start == stop: the sweep has one point.
  - single: one dwell, then DONE.
  - repeat / ping-pong: hold the point with `enable_out`=1 until `abort`.
- `abort` in any non-IDLE state: next cycle is IDLE, with `enable_out`=0, `busy`=0, no `done` pulse. `freq_out` holds its last value.
- `start` while busy is ignored.
- `start` and `abort` in the same IDLE cycle: abort wins and no sweep begins.
- `rst_in` overrides everything, including mid-sweep and a simultaneous start/abort.

## Timing
- Reset values: `freq_out`=0, `enable_out`=0, `busy`=0, `done`=0, state IDLE.
- Start accepted at edge t:
  - At t+1: `freq_out`=start, `enable_out`=1, `busy`=1.
  - Each point is presented for D = max(`cfg_dwell`,1) cycles, plus 1 STEP cycle. During the STEP cycle `freq_out` still holds the old value.
  - Period per point = D+1 cycles. The new value appears at t+1+(D+1)·k.
- Completion, single mode:
  - The last point holds for D cycles.
  - The next cycle is DONE, with `done`=1, `enable_out`=0, `busy`=1.
  - The cycle after that is IDLE, with `busy`=0.
  - A new `start` is accepted in that IDLE cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `waveform_pkg`: `sweep_mode_e` (SINGLE, REPEAT, PINGPONG) and `sweep_state_e` (IDLE, DWELL, STEP, DONE).
- One sub-module, `dwell_timer`: loadable down-counter with an `expired` flag, parameterised by DWELL_WIDTH.
- The next-point arithmetic stays inline in the FSM.

## Test plan
- Single up: start=100, stop=130, step=10, dwell=3 → `freq_out` sequence 100,110,120,130, each held 4 cycles (3 DWELL + 1 STEP, except the final point, which holds 3 cycles). Then `done` pulse exactly once, total 15 cycles after the start edge.
- Overshoot clamp, down: start=50, stop=5, step=20, dwell=1 → 50,30,10,5, then `done`. Underflow check: start=10, stop=0, step=30 → 10,0.
- Ping-pong: start=0, stop=2, step=1, dwell=1 → 0,1,2,1,0,1,2… with no endpoint repeated. `busy` stays high until `abort`.
- Abort mid-dwell at point 120 (single sweep as above) → next cycle `enable_out`=0, `busy`=0, no `done`, `freq_out`=120. A restart in the following cycle begins at 100.
- `rst_in` mid-sweep → all outputs 0 on the next edge. A simultaneous `start`+`abort` in IDLE leaves `busy`=0. `start` pulsed while busy does not alter the sequence.
- Repeat mode with `cfg_dwell`=0 and step overflow: start=0xFFF0, stop=0xFFFF, step=0x20 → 0xFFF0, 0xFFFF, 0xFFF0…, each point held 1 cycle + 1 STEP cycle.
